// File: rtl/equ_pkg.sv
// Shared types and symbol/index mapping for the
// equalizer read scheduler.
package equ_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EST,
    SELECT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int N_DATA_SYM = 6;
  localparam logic [2:0] IDX_NONE = 3'd7;

  function automatic logic [2:0] sym2idx(
    input logic [2:0] sym
  );
    logic [2:0] idx;
    case (sym)
      3'd1:    idx = 3'd0;
      3'd2:    idx = 3'd1;
      3'd3:    idx = 3'd2;
      3'd5:    idx = 3'd3;
      3'd6:    idx = 3'd4;
      3'd7:    idx = 3'd5;
      default: idx = IDX_NONE;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] idx2sym(
    input logic [2:0] idx
  );
    return (idx < 3'd3) ? idx + 3'd1
                        : idx + 3'd2;
  endfunction

endpackage

// File: rtl/equ_rd_pipe.sv
// Read-latency delay line carrying beat tags
// alongside the buffer read data.
module equ_rd_pipe #(
  parameter int SC_W   = 4,
  parameter int RD_LAT = 1
) (
  input  logic            i_clk_equ,
  input  logic            i_rst_n,
  input  logic            flush,
  input  logic            vld,
  input  logic [2:0]      sym,
  input  logic [SC_W-1:0] sc,
  input  logic            last,
  output logic            q_vld,
  output logic [2:0]      q_sym,
  output logic [SC_W-1:0] q_sc,
  output logic            q_last,
  output logic            busy
);

  localparam int W = SC_W + 5;

  logic [W-1:0] stg [RD_LAT];

  always_ff @(posedge i_clk_equ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++)
        stg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= {vld, sym, sc, last};
      for (int i = 1; i < RD_LAT; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign {q_vld, q_sym, q_sc, q_last} = stg[RD_LAT-1];

  // Beats still inside after the output stage retires
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++)
      busy = busy | stg[i][W-1];
  end

endmodule

// File: rtl/fsm_equ_rd_sched.sv
// Read-side scheduler: gates data symbols on the
// pilot estimate and streams subcarriers to the EQ.
module fsm_equ_rd_sched
  import equ_pkg::*;
#(
  parameter int N_SC   = 12,
  parameter int SC_W   = 4,
  parameter int RD_LAT = 1,
  parameter int ADD_W  = 7
) (
  input  logic             i_clk_equ,
  input  logic             i_rst_n,
  input  logic             i_slot_start,
  input  logic             i_sym_wr_done,
  input  logic [2:0]       i_symbol_num,
  input  logic             i_est_valid,
  input  logic             i_equ_ready,
  output logic             o_rd_en,
  output logic [ADD_W-1:0] o_rd_add,
  output logic             o_equ_valid,
  output logic [2:0]       o_equ_sym,
  output logic [SC_W-1:0]  o_equ_sc,
  output logic             o_equ_last,
  output logic             o_slot_done,
  output logic             o_overrun
);

  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'(N_SC - 1);

  state_t                state;
  logic [N_DATA_SYM-1:0] pending;
  logic [N_DATA_SYM-1:0] served;
  logic [N_DATA_SYM-1:0] pend_n;
  logic [N_DATA_SYM-1:0] srv_n;
  logic                  est_ok;
  logic                  est_n;
  logic [2:0]            cur_idx;
  logic [2:0]            wr_idx;
  logic [2:0]            sel_idx;
  logic [SC_W-1:0]       sc;
  logic                  in_run;
  logic                  beat;
  logic                  fin;
  logic                  wr_hit;
  logic                  ovr_hit;
  logic                  pipe_busy;

  assign wr_idx = sym2idx(i_symbol_num);
  assign in_run = (state == RUN);
  assign beat   = in_run & i_equ_ready;
  assign fin    = beat & (sc == SC_LAST);
  assign wr_hit = i_sym_wr_done
                & (wr_idx != IDX_NONE);
  assign est_n  = est_ok | i_est_valid;

  always_comb begin
    ovr_hit = 1'b0;
    if (wr_hit)
      ovr_hit = pending[wr_idx]
              | served[wr_idx]
              | (in_run & (cur_idx == wr_idx));
  end

  always_comb begin
    pend_n = pending;
    srv_n  = served;
    if (fin) begin
      pend_n[cur_idx] = 1'b0;
      srv_n[cur_idx]  = 1'b1;
    end
    if (wr_hit && !ovr_hit)
      pend_n[wr_idx] = 1'b1;
  end

  always_comb begin
    sel_idx = '0;
    for (int i = N_DATA_SYM - 1; i >= 0; i--)
      if (pending[i])
        sel_idx = 3'(i);
  end

  assign o_rd_en  = beat;
  assign o_rd_add = beat
    ? ADD_W'(cur_idx) * ADD_W'(N_SC) + ADD_W'(sc)
    : '0;

  equ_rd_pipe #(
    .SC_W   (SC_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .i_clk_equ (i_clk_equ),
    .i_rst_n   (i_rst_n),
    .flush     (i_slot_start),
    .vld       (beat),
    .sym       (idx2sym(cur_idx)),
    .sc        (sc),
    .last      (fin),
    .q_vld     (o_equ_valid),
    .q_sym     (o_equ_sym),
    .q_sc      (o_equ_sc),
    .q_last    (o_equ_last),
    .busy      (pipe_busy)
  );

  always_ff @(posedge i_clk_equ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      served      <= '0;
      est_ok      <= 1'b0;
      cur_idx     <= '0;
      sc          <= '0;
      o_slot_done <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (i_slot_start) begin
      state       <= WAIT_EST;
      pending     <= '0;
      served      <= '0;
      est_ok      <= 1'b0;
      cur_idx     <= '0;
      sc          <= '0;
      o_slot_done <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_slot_done <= 1'b0;
      if (state != IDLE) begin
        pending <= pend_n;
        served  <= srv_n;
        est_ok  <= est_n;
        if (ovr_hit)
          o_overrun <= 1'b1;
      end
      unique case (state)
        WAIT_EST: begin
          if (est_n)
            state <= SELECT;
        end
        SELECT: begin
          if (|pending) begin
            cur_idx <= sel_idx;
            sc      <= '0;
            state   <= RUN;
          end else if (&served) begin
            o_slot_done <= 1'b1;
            state       <= DONE;
          end
        end
        RUN: begin
          if (beat) begin
            sc <= sc + 1'b1;
            if (sc == SC_LAST)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy)
            state <= SELECT;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
